// File: rtl/k_alu_mc.sv
// k_alu_mc : multi-cycle ALU with valid/ready handshakes on both sides.
//
// Uses the same 4-bit function encoding as the older single-cycle K_ALU.
// MUL runs as a shift-add loop and DIV as a restoring loop, one bit per cycle.
// Every other code, and DIV by zero, finishes on the edge that accepts it.
// All results and flags are held in registers. The handshake outputs are
// decoded only from the state register.
//
// Ports
//   clk          : clock; all state changes on the rising edge
//   rst          : synchronous, active-high reset
//   in_valid     : A, B and ALU_Function are valid
//   in_ready     : block can accept an operation (IDLE only)
//   A, B         : operands, WIDTH bits each
//   ALU_Function : 4-bit operation select
//   Z            : registered result
//   out_valid    : Z and the flags are valid; held until out_ready
//   out_ready    : consumer takes the result
//   flag_zero    : Z == 0
//   flag_neg     : Z[WIDTH-1]
//   flag_carry   : carry out (add) or borrow (sub)
//   flag_ovf     : signed overflow (add/sub), or a nonzero upper product half (MUL)
//   div_by_zero  : DIV was issued with B == 0
module k_alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Function,
  output logic [WIDTH-1:0] Z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             div_by_zero
);

  localparam int MSB  = WIDTH - 1;
  localparam int CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNTW-1:0]    r_cnt;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_b;
  // MUL: {partial product high half, multiplier/low half}
  // DIV: {remainder, dividend bits shifting out / quotient bits shifting in}
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH-1:0]   r_z;
  logic               r_zero;
  logic               r_neg;
  logic               r_carry;
  logic               r_ovf;
  logic               r_dbz;

  // Single-cycle datapath
  logic [WIDTH-1:0]   w_four;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_inc;
  logic [WIDTH:0]     w_dec;
  logic               w_slt;
  logic               w_is_iter;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_dbz;

  // Iterative datapath
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_it_ovf;

  assign w_four    = {{(WIDTH-3){1'b0}}, 3'b100};
  assign w_sh      = B[SHW-1:0];
  assign w_add     = {1'b0, A} + {1'b0, B};
  assign w_sub     = {1'b0, A} - {1'b0, B};
  assign w_inc     = {1'b0, A} + {1'b0, w_four};
  assign w_dec     = {1'b0, A} - {1'b0, w_four};
  assign w_slt     = ($signed(A) < $signed(B));
  // DIV by zero takes the single-cycle path and returns all ones
  assign w_is_iter = (ALU_Function == 4'd2) ||
                     ((ALU_Function == 4'd3) && (B != {WIDTH{1'b0}}));

  // One shift-add step: add the multiplicand when the current multiplier bit is set, then shift right
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

  // One restoring step. The remainder stays below the divisor, so WIDTH+1 bits of shifted remainder are enough
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[MSB]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;

  assign w_it_ovf = (~r_is_div) & (|w_acc_nxt[2*WIDTH-1:WIDTH]);

  // Next accumulator value for the active iterative operation
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_is_div) begin
      if (w_div_ge) begin
        w_acc_nxt = {w_div_diff, r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Single-cycle result and carry/overflow for the operation currently on the inputs
  always_comb begin
    w_res   = {WIDTH{1'b0}};
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_dbz   = 1'b0;
    case (ALU_Function)
      4'd0: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (A[MSB] == B[MSB]) && (w_add[MSB] != A[MSB]);
      end
      4'd1: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (A[MSB] != B[MSB]) && (w_sub[MSB] != A[MSB]);
      end
      4'd3: begin
        w_res = {WIDTH{1'b1}};
        w_dbz = 1'b1;
      end
      4'd4:  w_res = A & B;
      4'd5:  w_res = A | B;
      4'd6:  w_res = A ^ B;
      4'd7:  w_res = ~A;
      4'd8:  w_res = A;
      4'd9:  w_res = B;
      4'd10: w_res = A << w_sh;
      4'd11: w_res = A >> w_sh;
      4'd12: w_res = $unsigned($signed(A) >>> w_sh);
      4'd13: begin
        w_res   = w_inc[WIDTH-1:0];
        w_carry = w_inc[WIDTH];
        w_ovf   = (A[MSB] == 1'b0) && (w_inc[MSB] != A[MSB]);
      end
      4'd14: begin
        w_res   = w_dec[WIDTH-1:0];
        w_carry = w_dec[WIDTH];
        w_ovf   = (A[MSB] == 1'b1) && (w_dec[MSB] != A[MSB]);
      end
      4'd15: w_res = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_res = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_is_iter) begin
            w_state_nxt = S_BUSY;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == CNTW'(1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, iteration and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= {CNTW{1'b0}};
      r_is_div <= 1'b0;
      r_b      <= {WIDTH{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_z      <= {WIDTH{1'b0}};
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // MUL and DIV both start with the A operand in the low half
            r_acc    <= {{WIDTH{1'b0}}, A};
            r_b      <= B;
            r_is_div <= (ALU_Function == 4'd3);
            if (w_is_iter) begin
              r_cnt <= CNTW'(WIDTH);
            end else begin
              r_cnt   <= {CNTW{1'b0}};
              r_z     <= w_res;
              r_zero  <= (w_res == {WIDTH{1'b0}});
              r_neg   <= w_res[MSB];
              r_carry <= w_carry;
              r_ovf   <= w_ovf;
              r_dbz   <= w_dbz;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CNTW'(1);
          // The last iteration and the result load happen on the same edge
          if (r_cnt == CNTW'(1)) begin
            r_z     <= w_acc_nxt[WIDTH-1:0];
            r_zero  <= (w_acc_nxt[WIDTH-1:0] == {WIDTH{1'b0}});
            r_neg   <= w_acc_nxt[MSB];
            r_carry <= 1'b0;
            r_ovf   <= w_it_ovf;
            r_dbz   <= 1'b0;
          end
        end
        S_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CNTW{1'b0}};
        end
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign Z           = r_z;
  assign flag_zero   = r_zero;
  assign flag_neg    = r_neg;
  assign flag_carry  = r_carry;
  assign flag_ovf    = r_ovf;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_k_alu_mc.sv
// Directed testbench for k_alu_mc with WIDTH=32.
// Each feature has its own task, and the checks sit inline in those tasks.
// Flag vectors are packed as {zero, neg, carry, ovf, div_by_zero}.
// Latency is the number of rising edges from the accept edge, inclusive,
// up to the first negedge at which out_valid is seen.
module tb_k_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  fn;
  logic [31:0] z;
  logic        out_valid;
  logic        out_ready;
  logic        f_zero, f_neg, f_carry, f_ovf, f_dbz;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  fn;
    logic [31:0] z;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  k_alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .ALU_Function(fn), .Z(z), .out_valid(out_valid),
    .out_ready(out_ready), .flag_zero(f_zero), .flag_neg(f_neg),
    .flag_carry(f_carry), .flag_ovf(f_ovf), .div_by_zero(f_dbz)
  );

  always #5 clk = ~clk;

  // Issue one op and wait for out_valid. lat is 0 on timeout.
  // The operands are scrambled after the accept edge.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                        input logic [3:0] vfn, output int lat);
    @(negedge clk);
    a = va; b = vb; fn = vfn; in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a = ~va; b = ~vb; fn = ~vfn;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 32'd5; b = 32'd6; fn = 4'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, z, f_zero, f_neg, f_carry, f_ovf, f_dbz} !== {1'b1, 1'b0, 32'd0, 5'b00000}) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b Z=%h flags=%b, want 1 0 0 00000",
               in_ready, out_valid, z, {f_zero, f_neg, f_carry, f_ovf, f_dbz});
    end
  endtask

  task automatic test_arith();
    vec_t tv[8];
    int lat;
    tv[0] = '{32'd34, 32'd3, 4'd0, 32'd37, 5'b00000, 1};
    tv[1] = '{32'd34, 32'd3, 4'd1, 32'd31, 5'b00000, 1};
    tv[2] = '{32'hFFFFFFFF, 32'd3, 4'd15, 32'd1, 5'b00000, 1};
    tv[3] = '{32'd3, 32'hFFFFFFFF, 4'd15, 32'd0, 5'b10000, 1};
    tv[4] = '{32'hFFFFFFFF, 32'd1, 4'd0, 32'd0, 5'b10100, 1};
    tv[5] = '{32'h7FFFFFFE, 32'd0, 4'd13, 32'h80000002, 5'b01010, 1};
    tv[6] = '{32'd2, 32'd0, 4'd14, 32'hFFFFFFFE, 5'b01100, 1};
    tv[7] = '{32'h0, 32'h0, 4'd7, 32'hFFFFFFFF, 5'b01000, 1};
    for (int i = 0; i < 8; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].fn, lat);
      n_cmp++;
      if ({z, f_zero, f_neg, f_carry, f_ovf, f_dbz} !== {tv[i].z, tv[i].fl} || lat != tv[i].lat) begin
        n_err++;
        $display("FAIL arith[%0d]: Z=%h flags=%b lat=%0d, want Z=%h flags=%b lat=%0d",
                 i, z, {f_zero, f_neg, f_carry, f_ovf, f_dbz}, lat, tv[i].z, tv[i].fl, tv[i].lat);
      end
      release_op();
    end
  endtask

  task automatic test_shift();
    vec_t tv[5];
    int lat;
    tv[0] = '{32'h80000000, 32'h24, 4'd12, 32'hF8000000, 5'b01000, 1};
    tv[1] = '{32'h80000000, 32'h24, 4'd11, 32'h08000000, 5'b00000, 1};
    tv[2] = '{32'h80000000, 32'd1, 4'd1, 32'h7FFFFFFF, 5'b00010, 1};
    tv[3] = '{32'd1, 32'h21, 4'd10, 32'd2, 5'b00000, 1};
    tv[4] = '{32'hF0F0_1234, 32'h0FF0_00FF, 4'd6, 32'hFF00_12CB, 5'b01000, 1};
    for (int i = 0; i < 5; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].fn, lat);
      n_cmp++;
      if ({z, f_zero, f_neg, f_carry, f_ovf, f_dbz} !== {tv[i].z, tv[i].fl} || lat != tv[i].lat) begin
        n_err++;
        $display("FAIL shift[%0d]: Z=%h flags=%b lat=%0d, want Z=%h flags=%b lat=%0d",
                 i, z, {f_zero, f_neg, f_carry, f_ovf, f_dbz}, lat, tv[i].z, tv[i].fl, tv[i].lat);
      end
      release_op();
    end
  endtask

  task automatic test_mul();
    vec_t tv[3];
    int lat;
    tv[0] = '{32'd34, 32'd3, 4'd2, 32'd102, 5'b00000, 33};
    tv[1] = '{32'h10000, 32'h10000, 4'd2, 32'd0, 5'b10010, 33};
    tv[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'd1, 5'b00010, 33};
    for (int i = 0; i < 3; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].fn, lat);
      n_cmp++;
      if ({z, f_zero, f_neg, f_carry, f_ovf, f_dbz} !== {tv[i].z, tv[i].fl} || lat != tv[i].lat) begin
        n_err++;
        $display("FAIL mul[%0d]: Z=%h flags=%b lat=%0d, want Z=%h flags=%b lat=%0d",
                 i, z, {f_zero, f_neg, f_carry, f_ovf, f_dbz}, lat, tv[i].z, tv[i].fl, tv[i].lat);
      end
      release_op();
    end
  endtask

  task automatic test_div();
    vec_t tv[5];
    int lat;
    tv[0] = '{32'd34, 32'd3, 4'd3, 32'd11, 5'b00000, 33};
    tv[1] = '{32'd34, 32'd0, 4'd3, 32'hFFFFFFFF, 5'b01001, 1};
    tv[2] = '{32'hFFFFFFFF, 32'd1, 4'd3, 32'hFFFFFFFF, 5'b01000, 33};
    tv[3] = '{32'd100, 32'd7, 4'd3, 32'd14, 5'b00000, 33};
    tv[4] = '{32'd5, 32'd7, 4'd3, 32'd0, 5'b10000, 33};
    for (int i = 0; i < 5; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].fn, lat);
      n_cmp++;
      if ({z, f_zero, f_neg, f_carry, f_ovf, f_dbz} !== {tv[i].z, tv[i].fl} || lat != tv[i].lat) begin
        n_err++;
        $display("FAIL div[%0d]: Z=%h flags=%b lat=%0d, want Z=%h flags=%b lat=%0d",
                 i, z, {f_zero, f_neg, f_carry, f_ovf, f_dbz}, lat, tv[i].z, tv[i].fl, tv[i].lat);
      end
      release_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'd5, 32'd6, 4'd0, lat);
    for (int i = 0; i < 5; i++) begin
      // A competing request while DONE must be ignored
      in_valid = 1'b1; a = 32'd100; b = 32'd100; fn = 4'd0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, z, f_zero, f_neg, f_carry, f_ovf, f_dbz} !== {1'b1, 1'b0, 32'd11, 5'b00000}) begin
        n_err++;
        $display("FAIL hold[%0d]: out_valid=%b in_ready=%b Z=%h, want 1 0 0000000b", i, out_valid, in_ready, z);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    bit stale;
    @(negedge clk);
    a = 32'd34; b = 32'd3; fn = 4'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, z} !== {1'b0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL mid_rst: out_valid=%b in_ready=%b Z=%h, want 0 1 00000000", out_valid, in_ready, z);
    end
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) stale = 1'b1;
    end
    n_cmp++;
    if (stale) begin
      n_err++;
      $display("FAIL stale: out_valid seen=1 after reset, want 0");
    end
    run_op(32'd1, 32'd2, 4'd0, lat);
    n_cmp++;
    if (z !== 32'd3 || lat != 1) begin
      n_err++;
      $display("FAIL post_rst: Z=%h lat=%0d, want Z=00000003 lat=1", z, lat);
    end
    release_op();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/k_alu_mc.md
# k_alu_mc

Parametrised multi-cycle ALU, successor to the single-cycle combinational K_ALU. It keeps the existing 4-bit function encoding, adds a valid/ready handshake on both sides, iterative multiply/divide, a signed compare op and status flags. It sits between the register-read stage and writeback in the multi-cycle datapath.

## Interface
- WIDTH, 32: operand/result width; legal values 8–64, power of two.
- SHW, $clog2(WIDTH): derived; shift-amount bits taken from B.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and function valid.
- in_ready  out  1  block can accept; high only in IDLE.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALU_Function  in  4  operation select.
- Z  out  WIDTH  registered result.
- out_valid  out  1  Z/flags valid; held until taken.
- out_ready  in  1  consumer accepts result.
- flag_zero  out  1  Z == 0.
- flag_neg  out  1  Z[WIDTH-1].
- flag_carry  out  1  carry-out (add), borrow (sub).
- flag_ovf  out  1  signed overflow (add/sub); nonzero upper product half (MUL).
- div_by_zero  out  1  DIV issued with B == 0.

## Operation
- Codes: 0 A+B, 1 A−B, 2 A*B (low WIDTH bits, unsigned), 3 A/B (unsigned quotient), 4 A&B, 5 A|B, 6 A^B, 7 ~A, 8 A, 9 B, 10 A<<B[SHW-1:0], 11 A>>B[SHW-1:0] logical, 12 A>>>B[SHW-1:0] arithmetic, 13 A+4, 14 A−4, 15 SLT: Z = ($signed(A) < $signed(B)) ? 1 : 0.
- Shift amount uses only B[SHW-1:0]; upper B bits ignored.
- Handshake accepted on edge where in_valid && in_ready; operands latched, later input changes ignored.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Accept of codes 2 or 3 (B≠0) → BUSY with counter=WIDTH; any other code (incl. DIV by 0) → DONE with result computed same edge.
  - BUSY: one iteration per cycle — MUL shift-add on 2*WIDTH accumulator, DIV restoring (one quotient bit per cycle). Counter decrements; at counter==1 edge result loads → DONE.
  - DONE: out_valid=1, Z/flags stable. out_ready=1 → IDLE on that edge. out_ready=0 → stay, values held.
- DIV with B==0: Z = all ones, div_by_zero=1, flag_carry=0, flag_ovf=0; single-cycle.
- Flags computed from final result; carry/ovf = 0 for codes 3–12, 15. Codes 13/14 set carry/ovf as add/sub with constant 4. flag_zero and flag_neg valid for all codes.
- div_by_zero is 0 for every result except DIV-by-zero.

## Timing
- Reset (any state, incl. mid-BUSY): state→IDLE, counter cleared, Z=0, all flags 0, div_by_zero=0, out_valid=0; in_ready=1 the cycle after the reset edge. In-flight op discarded, no result emitted.
- in_valid while rst=1: ignored.
- Single-cycle op accepted at edge T: out_valid=1 from T+1.
- MUL/DIV accepted at edge T: out_valid=1 from T+WIDTH+1 (32 → 33 cycles).
- Earliest next accept: edge after the out_valid && out_ready edge (no overlap, one op in flight).
- in_ready=0 during BUSY and DONE; in_valid there has no effect.
- All outputs registered; no combinational path input→output except none (in_ready from state only).

## Test plan
- WIDTH=32, A=34, B=3, code 0 → out_valid 1 cycle after accept, Z=37, flags all 0; code 1 → Z=31; code 15 with A=0xFFFFFFFF, B=3 → Z=1.
- A=34, B=3, code 2 → out_valid exactly 33 cycles after accept, Z=102, flag_ovf=0; A=0x10000, B=0x10000 → Z=0, flag_zero=1, flag_ovf=1.
- A=34, B=3, code 3 → Z=11 after 33 cycles; B=0 → Z=0xFFFFFFFF, div_by_zero=1, out_valid after 1 cycle.
- Code 12, A=0x80000000, B=0x24 (shift 4) → Z=0xF8000000, flag_neg=1; code 11 same inputs → Z=0x08000000; code 1, A=0x80000000, B=1 → Z=0x7FFFFFFF, flag_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → Z, flags, out_valid stable, in_ready=0; out_ready=1 → next cycle in_ready=1, out_valid=0.
- Assert rst at cycle 10 of a MUL → next cycle out_valid=0, Z=0, in_ready=1; no stale result; following code 0 op A=1, B=2 → Z=3.
